// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation encodings,
// burst controller state encoding and a shift-class helper.
package univ_shift_reg_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'd0,
      MODE_LOAD = 3'd1,
      MODE_SHR  = 3'd2,
      MODE_SHL  = 3'd3,
      MODE_ROR  = 3'd4,
      MODE_ROL  = 3'd5,
      MODE_CLR  = 3'd6,
      MODE_RSVD = 3'd7
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   // Only shifts and rotates may be repeated as a counted burst.
   function automatic logic is_shift_mode(input logic [2:0] m);
      return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) || (m == MODE_ROL);
   endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: accepts a counted shift request, steps a down-counter on
// every enabled edge while RUN, and pulses done from the FIN state.
module shift_burst_ctrl
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [2:0]    mode,
   input  logic          start,
   input  logic [CW-1:0] count,
   output logic          busy,
   output logic          done,
   output logic          shift_en,
   output logic          accept,
   output logic [2:0]    op,
   output state_e        state_o
);

   localparam logic [CW-1:0] MAX_CNT = CW'(WIDTH);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    op_q, op_d;
   logic [CW-1:0] sat_cnt;

   assign sat_cnt = (count > MAX_CNT) ? MAX_CNT : count;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      shift_en = 1'b0;
      accept   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en && start && is_shift_mode(mode)) begin
               accept  = 1'b1;
               op_d    = mode;
               cnt_d   = sat_cnt;
               state_d = (sat_cnt == '0) ? ST_FIN : ST_RUN;
            end
         end
         ST_RUN: begin
            if (en) begin
               shift_en = 1'b1;
               cnt_d    = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            if (en) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= MODE_HOLD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   assign busy    = (state_q == ST_RUN);
   assign done    = (state_q == ST_FIN);
   assign op      = op_q;
   assign state_o = state_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: direct load/shift/rotate/clear ops from IDLE, or a
// counted burst of one shift op sequenced by shift_burst_ctrl.
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic             start,
   input  logic [CW-1:0]    count,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic             busy,
   output logic             done
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             shift_en, accept, direct_en;
   logic [2:0]       op;
   state_e           ctrl_state;

   shift_burst_ctrl #(.WIDTH(WIDTH), .CW(CW)) u_ctrl (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .mode     (mode),
      .start    (start),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .shift_en (shift_en),
      .accept   (accept),
      .op       (op),
      .state_o  (ctrl_state)
   );

   function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       m,
                                                 input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] ld,
                                                 input logic             sr,
                                                 input logic             sl);
      case (m)
         MODE_LOAD: return ld;
         MODE_SHR:  return {sr, v[WIDTH-1:1]};
         MODE_SHL:  return {v[WIDTH-2:0], sl};
         MODE_ROR:  return {v[0], v[WIDTH-1:1]};
         MODE_ROL:  return {v[WIDTH-2:0], v[WIDTH-1]};
         MODE_CLR:  return '0;
         default:   return v;
      endcase
   endfunction

   // An accepted start holds q for that edge, so it pre-empts the direct op.
   assign direct_en = en && (ctrl_state == ST_IDLE) && !accept;

   always_comb begin
      data_d = data_q;
      if (shift_en)
         data_d = apply_op(op, data_q, din, sin_r, sin_l);
      else if (direct_en)
         data_d = apply_op(mode, data_q, din, sin_r, sin_l);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
   end

   assign q      = data_q;
   assign sout_r = data_q[0];
   assign sout_l = data_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: a 4-bit instance for the basic shift
// sequence and an 8-bit instance for rotate, burst, enable and reset cases.
module tb_univ_shift_reg;
   import univ_shift_reg_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic       en, sin_r, sin_l, start, sout_r, sout_l, busy, done;
   logic [2:0] mode;
   logic [7:0] din, q;
   logic [3:0] count;

   logic       en4, sin_r4, sin_l4, start4, sout_r4, sout_l4, busy4, done4;
   logic [2:0] mode4, count4;
   logic [3:0] din4, q4;

   int n_cmp = 0;
   int n_bad = 0;

   univ_shift_reg #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din),
      .sin_r(sin_r), .sin_l(sin_l), .start(start), .count(count),
      .q(q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
   );

   univ_shift_reg #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .din(din4),
      .sin_r(sin_r4), .sin_l(sin_l4), .start(start4), .count(count4),
      .q(q4), .sout_r(sout_r4), .sout_l(sout_l4), .busy(busy4), .done(done4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL reset_q8 got=%h exp=00", q); end
      n_cmp++; if (q4 !== 4'h0) begin n_bad++; $display("FAIL reset_q4 got=%h exp=0", q4); end
      n_cmp++; if ({busy, done, sout_r, sout_l} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags8 got=%b exp=0000", {busy, done, sout_r, sout_l}); end
      n_cmp++; if ({busy4, done4, sout_r4, sout_l4} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags4 got=%b exp=0000", {busy4, done4, sout_r4, sout_l4}); end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_w4_shr();
      logic [3:0] exp_v [3] = '{4'b0101, 4'b0010, 4'b0001};
      en4 = 1'b1; mode4 = MODE_LOAD; din4 = 4'b1011;
      step();
      n_cmp++; if (q4 !== 4'b1011) begin n_bad++; $display("FAIL w4_load got=%b exp=1011", q4); end
      n_cmp++; if (sout_r4 !== 1'b1) begin n_bad++; $display("FAIL w4_load_sout got=%b exp=1", sout_r4); end
      mode4 = MODE_SHR; sin_r4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (q4 !== exp_v[i]) begin n_bad++; $display("FAIL w4_shr%0d got=%b exp=%b", i, q4, exp_v[i]); end
         n_cmp++; if (sout_r4 !== exp_v[i][0]) begin n_bad++; $display("FAIL w4_sout%0d got=%b exp=%b", i, sout_r4, exp_v[i][0]); end
      end
      en4 = 1'b0;
   endtask

   task automatic test_rotate();
      en = 1'b1; mode = MODE_LOAD; din = 8'h81;
      step();
      n_cmp++; if (q !== 8'h81) begin n_bad++; $display("FAIL rot_load got=%h exp=81", q); end
      n_cmp++; if (sout_l !== 1'b1) begin n_bad++; $display("FAIL rot_sout_l got=%b exp=1", sout_l); end
      mode = MODE_ROL;
      step();
      n_cmp++; if (q !== 8'h03) begin n_bad++; $display("FAIL rol1 got=%h exp=03", q); end
      mode = MODE_ROR;
      step();
      n_cmp++; if (q !== 8'h81) begin n_bad++; $display("FAIL ror1 got=%h exp=81", q); end
      step();
      n_cmp++; if (q !== 8'hC0) begin n_bad++; $display("FAIL ror2 got=%h exp=c0", q); end
      mode = MODE_CLR;
      step();
      n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL clr got=%h exp=00", q); end
   endtask

   task automatic test_burst_shl();
      logic [7:0] exp_v [4] = '{8'h4B, 8'h97, 8'h2F, 8'h5F};
      mode = MODE_LOAD; din = 8'hA5;
      step();
      mode = MODE_SHL; start = 1'b1; count = 4'd4; sin_l = 1'b1;
      step();
      n_cmp++; if (q !== 8'hA5) begin n_bad++; $display("FAIL shl_accept_q got=%h exp=a5", q); end
      n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL shl_accept_flags got=%b exp=10", {busy, done}); end
      din = 8'hFF; count = 4'd1;
      for (int i = 0; i < 4; i++) begin
         mode  = (i % 2 == 1) ? MODE_CLR : MODE_LOAD;
         start = (i == 1);
         step();
         n_cmp++; if (q !== exp_v[i]) begin n_bad++; $display("FAIL shl_q%0d got=%h exp=%h", i, q, exp_v[i]); end
         n_cmp++; if (busy !== (i < 3)) begin n_bad++; $display("FAIL shl_busy%0d got=%b exp=%b", i, busy, (i < 3)); end
         n_cmp++; if (done !== (i == 3)) begin n_bad++; $display("FAIL shl_done%0d got=%b exp=%b", i, done, (i == 3)); end
      end
      mode = MODE_HOLD; start = 1'b0;
      step();
      n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL shl_after_flags got=%b exp=00", {busy, done}); end
      n_cmp++; if (q !== 8'h5F) begin n_bad++; $display("FAIL shl_after_q got=%h exp=5f", q); end
   endtask

   task automatic test_count_zero();
      mode = MODE_SHR; start = 1'b1; count = 4'd0;
      step();
      n_cmp++; if ({busy, done} !== 2'b01) begin n_bad++; $display("FAIL cz_flags got=%b exp=01", {busy, done}); end
      n_cmp++; if (q !== 8'h5F) begin n_bad++; $display("FAIL cz_q got=%h exp=5f", q); end
      mode = MODE_SHL; count = 4'd2;
      step();
      n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL cz_fin_start got=%b exp=00", {busy, done}); end
      n_cmp++; if (q !== 8'h5F) begin n_bad++; $display("FAIL cz_fin_q got=%h exp=5f", q); end
      mode = MODE_LOAD; din = 8'h3C; count = 4'd3;
      step();
      n_cmp++; if (q !== 8'h3C) begin n_bad++; $display("FAIL start_load_q got=%h exp=3c", q); end
      n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL start_load_flags got=%b exp=00", {busy, done}); end
      mode = MODE_HOLD; start = 1'b0;
      step();
      n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL start_load_after got=%b exp=00", {busy, done}); end
   endtask

   task automatic test_saturate();
      logic [7:0] exp_q;
      mode = MODE_LOAD; din = 8'hFF;
      step();
      mode = MODE_SHR; start = 1'b1; count = 4'd15; sin_r = 1'b0;
      step();
      start = 1'b0; mode = MODE_HOLD;
      for (int i = 0; i < 8; i++) begin
         step();
         exp_q = 8'hFF >> (i + 1);
         n_cmp++; if (q !== exp_q) begin n_bad++; $display("FAIL sat_q%0d got=%h exp=%h", i, q, exp_q); end
         n_cmp++; if ({busy, done} !== {(i < 7), (i == 7)}) begin n_bad++; $display("FAIL sat_flags%0d got=%b exp=%b", i, {busy, done}, {(i < 7), (i == 7)}); end
      end
      step();
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL sat_done_clear got=%b exp=0", done); end
   endtask

   task automatic test_en_gap();
      mode = MODE_LOAD; din = 8'h01;
      step();
      mode = MODE_ROL; start = 1'b1; count = 4'd6;
      step();
      start = 1'b0; mode = MODE_HOLD;
      repeat (3) step();
      n_cmp++; if (q !== 8'h08) begin n_bad++; $display("FAIL gap_q3 got=%h exp=08", q); end
      en = 1'b0;
      repeat (2) step();
      n_cmp++; if (q !== 8'h08) begin n_bad++; $display("FAIL gap_frozen_q got=%h exp=08", q); end
      n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL gap_frozen_flags got=%b exp=10", {busy, done}); end
      en = 1'b1;
      repeat (2) step();
      n_cmp++; if ({q, busy, done} !== {8'h20, 2'b10}) begin n_bad++; $display("FAIL gap_q5 got=%h/%b exp=20/10", q, {busy, done}); end
      step();
      n_cmp++; if ({q, busy, done} !== {8'h40, 2'b01}) begin n_bad++; $display("FAIL gap_done got=%h/%b exp=40/01", q, {busy, done}); end
      en = 1'b0;
      step();
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL gap_done_held got=%b exp=1", done); end
      en = 1'b1;
      step();
      n_cmp++; if ({q, busy, done} !== {8'h40, 2'b00}) begin n_bad++; $display("FAIL gap_idle got=%h/%b exp=40/00", q, {busy, done}); end
   endtask

   task automatic test_async_reset();
      mode = MODE_LOAD; din = 8'hFF;
      step();
      mode = MODE_SHR; start = 1'b1; count = 4'd5; sin_r = 1'b0;
      step();
      start = 1'b0; mode = MODE_HOLD;
      step();
      n_cmp++; if ({q, busy} !== {8'h7F, 1'b1}) begin n_bad++; $display("FAIL ar_pre got=%h/%b exp=7f/1", q, busy); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL ar_q got=%h exp=00", q); end
      n_cmp++; if ({busy, done, sout_r, sout_l} !== 4'b0000) begin n_bad++; $display("FAIL ar_flags got=%b exp=0000", {busy, done, sout_r, sout_l}); end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         n_cmp++; if ({q, busy, done} !== 10'd0) begin n_bad++; $display("FAIL ar_after%0d got=%h/%b exp=00/00", i, q, {busy, done}); end
      end
   endtask

   initial begin
      en = 1'b0; mode = MODE_HOLD; din = '0; sin_r = 1'b0; sin_l = 1'b0; start = 1'b0; count = '0;
      en4 = 1'b0; mode4 = MODE_HOLD; din4 = '0; sin_r4 = 1'b0; sin_l4 = 1'b0; start4 = 1'b0; count4 = '0;
      test_reset();
      test_w4_shr();
      test_rotate();
      test_burst_shl();
      test_count_zero();
      test_saturate();
      test_en_gap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
